mat_op_sched: RTL
=================

Name: mat_op_sched

Overview:
- Shares the single matrix-operation engine between NUM_REQ command sources (keypad UI, UART host, ...) and sequences each operation.
- Per operation: round-robin grant, one-cycle launch pulse to the engine, wait for done or error, then a status response to the owning requester.
- Recovers the engine from its sticky error state and from hangs (watchdog plus engine reset).
- Sits between the command front-ends and the engine; matrix data and dimensions are routed to the engine directly, not through this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYC, 1024, watchdog cycles from launch to done/error before declaring timeout.
- ID_W, 2, width of the requester index field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_op  in  3*NUM_REQ  op code per requester; slice i is [3i+2:3i].
- req_scalar  in  8*NUM_REQ  signed scalar k per requester.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_op_sel  out  3  latched op code.
- eng_scalar_k  out  8  latched scalar.
- eng_owner  out  ID_W  index of the granted requester (steers the data muxes).
- eng_rst  out  1  one-cycle engine reset pulse after a timeout.
- eng_busy  in  1  engine busy.
- eng_done  in  1  engine done pulse.
- eng_error  in  1  engine error flag (sticky until the next start).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  requester the response belongs to.
- rsp_status  out  2  00 OK, 01 ENG_ERR, 10 TIMEOUT, 11 BAD_OP.
- sched_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: every output is 0, rr pointer = NUM_REQ-1 (so requester 0 has priority first), watchdog = 0, state = IDLE.
- IDLE:
  - req_ready[w] = 1 combinationally for the round-robin winner w among the asserted req_valid bits; search starts at pointer+1 and wraps.
  - On accept: latch op, scalar and w; set pointer = w.
  - If op > 3'b100 → RESP with BAD_OP; the engine is not touched.
  - Otherwise → LAUNCH.
- LAUNCH: assert eng_start for exactly 1 cycle, clear the watchdog → WAIT. Accept-to-eng_start latency is exactly 1 cycle.
- WAIT:
  - eng_start low; watchdog increments every cycle.
  - eng_error high → CLEAR with status ENG_ERR.
  - Else eng_done high → RESP with OK.
  - If eng_error and eng_done are both high in the same cycle, error wins.
  - Watchdog reaching TIMEOUT_CYC-1 with neither seen → pulse eng_rst for 1 cycle, → RESP with TIMEOUT.
  - eng_done/eng_error arriving in the same cycle as the watchdog terminal count win over the timeout.
- CLEAR: one eng_start pulse returns the engine from its error state to idle. Then wait for eng_error = 0, bounded by the same watchdog (expiry → eng_rst pulse), → RESP with ENG_ERR.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_status are held stable until rsp_ready.
  - On rsp_valid & rsp_ready → IDLE.
  - The next grant can occur in the cycle after the response handshake, never in the same cycle.
- Ignored inputs: eng_done/eng_error outside WAIT/CLEAR; req_valid outside IDLE (req_ready = 0).
- Dropping req_valid while not granted is legal and loses nothing.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
- rst mid-operation: the block returns to its reset state the next edge and issues no response. The engine shares rst, so no eng_rst pulse is issued.

Optional Feature:
- Macro: MAT_SCHED_STATS_EN.
- Defined: adds three outputs, stat_ok, stat_err and stat_tmo, each 16 bits. Each increments on the RESP handshake carrying its status; they saturate at 16'hFFFF and clear on rst. BAD_OP is counted in stat_err.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mat_ctrl_pkg:
  - op codes: TRANSPOSE=0, ADD=1, SCALAR=2, MULTIPLY=3, CONV=4, OP_MAX=4.
  - status codes OK/ENG_ERR/TIMEOUT/BAD_OP.
  - scheduler state encoding IDLE/LAUNCH/WAIT/CLEAR/RESP.
- Sub-module: mat_rr_arb (NUM_REQ-bit request vector, pointer in; one-hot grant and index out), purely combinational. The pointer register stays in mat_op_sched.

Test Plan:
- Req0 ADD, engine done 6 cycles after start → eng_start exactly 1 cycle after accept, eng_op_sel=1; rsp_id=0, rsp_status=00.
- Req0 and req1 valid continuously with MULTIPLY → grants alternate 0,1,0,1; eng_owner matches each grant; no double start.
- Req1 op=3'b111 → no eng_start; rsp_id=1, rsp_status=11 on the cycle after accept.
- Engine raises eng_error after start → second eng_start pulse (clear); rsp_status=01 once eng_error falls; the next request launches normally.
- Engine silent, TIMEOUT_CYC=16 → eng_rst pulses for 1 cycle 16 cycles after launch; rsp_status=10.
- rst asserted in WAIT with rsp_ready held low → all outputs 0 next cycle, no rsp_valid; a fresh request is granted to req0.

Source files
------------

// File: rtl/mat_ctrl_pkg.sv
// Shared types for the matrix-operation scheduler: op codes, response status codes and
// scheduler FSM states.
package mat_ctrl_pkg;

  typedef enum logic [2:0] {
    OpTranspose = 3'd0,
    OpAdd       = 3'd1,
    OpScalar    = 3'd2,
    OpMultiply  = 3'd3,
    OpConv      = 3'd4
  } mat_op_e;

  localparam logic [2:0] OpMax = 3'd4;

  typedef enum logic [1:0] {
    StatOk      = 2'b00,
    StatEngErr  = 2'b01,
    StatTimeout = 2'b10,
    StatBadOp   = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StClear,
    StResp
  } sched_state_e;

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mat_op_sched_if.sv
// Control link between the scheduler (master) and the matrix engine (slave).
interface mat_op_sched_if #(
  parameter int unsigned ID_W = 2
) ();

  logic            eng_start;
  logic [2:0]      eng_op_sel;
  logic [7:0]      eng_scalar_k;
  logic [ID_W-1:0] eng_owner;
  logic            eng_rst;
  logic            eng_busy;
  logic            eng_done;
  logic            eng_error;

  modport master (
    output eng_start, eng_op_sel, eng_scalar_k, eng_owner, eng_rst,
    input  eng_busy, eng_done, eng_error
  );

  modport slave (
    input  eng_start, eng_op_sel, eng_scalar_k, eng_owner, eng_rst,
    output eng_busy, eng_done, eng_error
  );

endinterface

// File: rtl/mat_rr_arb.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps.
module mat_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mat_op_sched.sv
// Round-robin scheduler sharing one matrix engine between NUM_REQ command sources, with
// error clearing and a launch watchdog. Optional MAT_SCHED_STATS_EN adds response counters.
module mat_op_sched
  import mat_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned ID_W        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [3*NUM_REQ-1:0] req_op,
  input  logic [8*NUM_REQ-1:0] req_scalar,
  mat_op_sched_if.master       eng,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [1:0]           rsp_status,
  output logic                 sched_busy
`ifdef MAT_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_ok,
  output logic [15:0]          stat_err,
  output logic [15:0]          stat_tmo
`endif
);

  localparam int unsigned   WdW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

  sched_state_e    state_q, state_d;
  status_e         status_q, status_d;
  logic [2:0]      op_q, op_d;
  logic [7:0]      scalar_q, scalar_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            clr_first_q, clr_first_d;
  logic            start, erst;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;

  mat_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    op_d        = op_q;
    scalar_d    = scalar_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    wd_d        = wd_q;
    clr_first_d = clr_first_q;
    req_ready   = '0;
    start       = 1'b0;
    erst        = 1'b0;
    rsp_valid   = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = grant;
        if (|req_valid) begin
          op_d     = req_op[3*grant_idx +: 3];
          scalar_d = req_scalar[8*grant_idx +: 8];
          owner_d  = grant_idx;
          ptr_d    = grant_idx;
          if (req_op[3*grant_idx +: 3] > OpMax) begin
            status_d = StatBadOp;
            state_d  = StResp;
          end else begin
            state_d = StLaunch;
          end
        end
      end
      StLaunch: begin
        start   = 1'b1;
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        wd_d = wd_q + WdW'(1);
        if (eng.eng_error) begin
          status_d    = StatEngErr;
          clr_first_d = 1'b1;
          state_d     = StClear;
        end else if (eng.eng_done) begin
          status_d = StatOk;
          state_d  = StResp;
        end else if (wd_q == WdLast) begin
          erst     = 1'b1;
          status_d = StatTimeout;
          state_d  = StResp;
        end
      end
      StClear: begin
        // First cycle re-starts the engine to drop its sticky error, then wait for it to clear.
        if (clr_first_q) begin
          start       = 1'b1;
          wd_d        = '0;
          clr_first_d = 1'b0;
        end else begin
          wd_d = wd_q + WdW'(1);
          if (!eng.eng_error) begin
            state_d = StResp;
          end else if (wd_q == WdLast) begin
            erst    = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      status_q    <= StatOk;
      op_q        <= '0;
      scalar_q    <= '0;
      owner_q     <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      wd_q        <= '0;
      clr_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      op_q        <= op_d;
      scalar_q    <= scalar_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      wd_q        <= wd_d;
      clr_first_q <= clr_first_d;
    end
  end

  assign eng.eng_start    = start;
  assign eng.eng_rst      = erst;
  assign eng.eng_op_sel   = op_q;
  assign eng.eng_scalar_k = scalar_q;
  assign eng.eng_owner    = owner_q;
  assign rsp_id           = owner_q;
  assign rsp_status       = status_q;
  assign sched_busy       = (state_q != StIdle);

  logic unused_busy;
  assign unused_busy = eng.eng_busy;

`ifdef MAT_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ok  <= '0;
      stat_err <= '0;
      stat_tmo <= '0;
    end else if (rsp_valid && rsp_ready) begin
      case (status_q)
        StatOk:      stat_ok  <= sat_inc(stat_ok);
        StatTimeout: stat_tmo <= sat_inc(stat_tmo);
        default:     stat_err <= sat_inc(stat_err);
      endcase
    end
  end
`endif

endmodule
